ssp_cmd_master: RTL and testbench

Upstream SSP bus master that feeds the ssp_uart slave interface.
- Accepts register commands (address, 12-bit data, write/read) on a valid/ready channel and buffers them in a small FIFO.
- Serialises each command into one SSP frame: SSP_SSEL, SSP_SOF, SSP_RA, SSP_WnR, SSP_DI, SSP_EOC.
- Captures SSP_DO on read frames and returns it on a response channel.
- Replaces ad-hoc direct pin driving in benches and in the host-side integration.

---
 rtl/ssp_cmd_pkg.sv | 15 +
 rtl/ssp_cmd_fifo.sv | 58 +++++
 rtl/ssp_cmd_master.sv | 128 ++++++++++++
 tb/tb_ssp_cmd_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_cmd_pkg.sv
// Shared types and constants for the SSP command master and its command FIFO.
package ssp_cmd_pkg;

    localparam int unsigned SSP_DATA_W = 12;
    localparam int unsigned SSP_RA_W   = 3;

    typedef struct packed {
        logic [SSP_RA_W-1:0]   ra;
        logic                  wnr;
        logic [SSP_DATA_W-1:0] di;
    } ssp_cmd_t;

    typedef enum logic [1:0] {StIdle, StFrame, StGap} ssp_state_e;

endpackage

// File: rtl/ssp_cmd_fifo.sv
// Synchronous FIFO of SSP commands; full_o is registered from the next-state count.
module ssp_cmd_fifo
    import ssp_cmd_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  ssp_cmd_t        wdata_i,
    input  logic            pop_i,
    output ssp_cmd_t        rdata_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    ssp_cmd_t        mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            full_q;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CntW'(Depth));
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/ssp_cmd_master.sv
// SSP bus master: queues register commands and plays each out as one SSP frame,
// returning read data on a valid/ready response channel.
module ssp_cmd_master
    import ssp_cmd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned GAP_LEN    = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [SSP_RA_W-1:0]   cmd_ra,
    input  logic                  cmd_wnr,
    input  logic [SSP_DATA_W-1:0] cmd_di,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [SSP_DATA_W-1:0] rsp_do,
    output logic [SSP_RA_W-1:0]   rsp_ra,
    output logic                  SSP_SSEL,
    output logic                  SSP_SOF,
    output logic                  SSP_EOC,
    output logic [SSP_RA_W-1:0]   SSP_RA,
    output logic                  SSP_WnR,
    output logic [SSP_DATA_W-1:0] SSP_DI,
    input  logic [SSP_DATA_W-1:0] SSP_DO,
    output logic                  busy
);

    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TimMax = (FRAME_LEN > GAP_LEN) ? FRAME_LEN : GAP_LEN;
    localparam int unsigned TimW   = $clog2(TimMax) + 1;
    localparam logic [TimW-1:0] FrameLast = TimW'(FRAME_LEN - 1);
    localparam logic [TimW-1:0] GapLast   = TimW'(GAP_LEN - 1);

    ssp_state_e      state_q;
    logic [TimW-1:0] tim_q;
    logic            run_q;
    ssp_cmd_t        push_cmd, head;
    logic            push, pop, rsp_free, fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    assign push_cmd  = '{ra: cmd_ra, wnr: cmd_wnr, di: cmd_di};
    // run_q holds ready low until the first clock after reset release.
    assign cmd_ready = run_q && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign rsp_free  = !rsp_valid || rsp_ready;
    assign pop       = (state_q == StIdle) && !fifo_empty && (head.wnr || rsp_free);
    assign busy      = (fifo_count != '0) || (state_q != StIdle);

    ssp_cmd_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .push_i  (push),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= StIdle;
            tim_q     <= '0;
            run_q     <= 1'b0;
            SSP_SSEL  <= 1'b0;
            SSP_SOF   <= 1'b0;
            SSP_EOC   <= 1'b0;
            SSP_RA    <= '0;
            SSP_WnR   <= 1'b0;
            SSP_DI    <= '0;
            rsp_valid <= 1'b0;
            rsp_do    <= '0;
            rsp_ra    <= '0;
        end else begin
            run_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        state_q  <= StFrame;
                        tim_q    <= '0;
                        SSP_SSEL <= 1'b1;
                        SSP_SOF  <= 1'b1;
                        SSP_RA   <= head.ra;
                        SSP_WnR  <= head.wnr;
                        SSP_DI   <= head.wnr ? head.di : '0;
                    end
                end
                StFrame: begin
                    SSP_SOF <= 1'b0;
                    if (tim_q == FrameLast) begin
                        state_q  <= StGap;
                        tim_q    <= '0;
                        SSP_SSEL <= 1'b0;
                        SSP_EOC  <= 1'b0;
                    end else begin
                        tim_q   <= tim_q + TimW'(1);
                        SSP_EOC <= (tim_q + TimW'(1) == FrameLast);
                    end
                end
                StGap: begin
                    if (tim_q == GapLast) begin
                        state_q <= StIdle;
                        tim_q   <= '0;
                    end else begin
                        tim_q <= tim_q + TimW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Read data is sampled at the edge closing the EOC cycle.
            if (state_q == StFrame && tim_q == FrameLast && !SSP_WnR) begin
                rsp_valid <= 1'b1;
                rsp_do    <= SSP_DO;
                rsp_ra    <= SSP_RA;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ssp_cmd_master.sv
// Randomised and directed bench for ssp_cmd_master, checked every cycle against a
// queue-plus-frame-position reference model.
module tb_ssp_cmd_master;

    localparam int DEPTH = 4;
    localparam int FL    = 16;
    localparam int GL    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_ra = '0;
    logic        cmd_wnr = 1'b0;
    logic [11:0] cmd_di = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [11:0] rsp_do;
    logic [2:0]  rsp_ra;
    logic        ssel, sof, eoc, wnr, busy;
    logic [2:0]  ra;
    logic [11:0] di;
    logic [11:0] sdo = '0;
    bit          fixed_do = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ssp_cmd_master #(
        .FIFO_DEPTH (DEPTH),
        .FRAME_LEN  (FL),
        .GAP_LEN    (GL)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ra    (cmd_ra),
        .cmd_wnr   (cmd_wnr),
        .cmd_di    (cmd_di),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_do    (rsp_do),
        .rsp_ra    (rsp_ra),
        .SSP_SSEL  (ssel),
        .SSP_SOF   (sof),
        .SSP_EOC   (eoc),
        .SSP_RA    (ra),
        .SSP_WnR   (wnr),
        .SSP_DI    (di),
        .SSP_DO    (sdo),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a command queue plus a frame position
    // (-1 idle, 0..FL-1 inside the frame, FL..FL+GL-1 in the gap).
    typedef struct {
        logic [2:0]  ra;
        logic        wnr;
        logic [11:0] di;
    } cmd_t;

    cmd_t        q[$];
    int          pos = -1;
    bit          m_ready = 1'b0;
    bit          m_rv = 1'b0;
    logic [2:0]  m_ra = '0, m_rra = '0;
    logic        m_wnr = 1'b0;
    logic [11:0] m_di = '0, m_rdo = '0;

    task automatic model_reset();
        q.delete();
        pos = -1; m_ready = 0; m_rv = 0;
        m_ra = '0; m_rra = '0; m_wnr = 0; m_di = '0; m_rdo = '0;
    endtask

    task automatic model_step();
        bit   take, rsp_free;
        cmd_t c;
        take     = cmd_valid && m_ready;
        rsp_free = !m_rv || rsp_ready;
        if (pos == FL - 1 && !m_wnr) begin
            m_rv = 1; m_rdo = sdo; m_rra = m_ra;
        end else if (m_rv && rsp_ready) begin
            m_rv = 0;
        end
        if (pos < 0) begin
            if (q.size() > 0 && (q[0].wnr || rsp_free)) begin
                c = q.pop_front();
                m_ra = c.ra; m_wnr = c.wnr; m_di = c.wnr ? c.di : 12'h000;
                pos = 0;
            end
        end else if (pos == FL + GL - 1) begin
            pos = -1;
        end else begin
            pos++;
        end
        if (take) q.push_back('{cmd_ra, cmd_wnr, cmd_di});
        m_ready = (q.size() < DEPTH);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Every falling edge: DUT against model, plus an independent SSEL width check.
    int run = 0;
    initial begin
        forever begin
            @(negedge clk);
            check_eq("cmd_ready", cmd_ready, m_ready);
            check_eq("busy", busy, (q.size() != 0 || pos >= 0));
            check_eq("ssel", ssel, (pos >= 0 && pos < FL));
            check_eq("sof", sof, (pos == 0));
            check_eq("eoc", eoc, (pos == FL - 1));
            check_eq("ssp_ra", ra, m_ra);
            check_eq("ssp_wnr", wnr, m_wnr);
            check_eq("ssp_di", di, m_di);
            check_eq("rsp_valid", rsp_valid, m_rv);
            check_eq("rsp_do", rsp_do, m_rdo);
            check_eq("rsp_ra", rsp_ra, m_rra);
            if (rst) begin
                run = 0;
            end else if (ssel) begin
                run++;
            end else begin
                if (run != 0) check_eq("ssel_len", run, FL);
                run = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        sdo = fixed_do ? 12'h5A3 : 12'($urandom);
    endtask

    task automatic send(input logic [2:0] a, input logic w, input logic [11:0] d);
        bit acc;
        int k;
        cmd_valid = 1; cmd_ra = a; cmd_wnr = w; cmd_di = d;
        k = 0;
        do begin
            acc = m_ready;
            tick();
            k++;
        end while (!acc && k < 200);
        if (!acc) check_eq("send_timeout", {31'b0, acc}, 1);
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (!(q.size() == 0 && pos < 0) && k < budget) begin
            tick();
            k++;
        end
        check_eq("idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();
        check_eq("ready_after_reset", cmd_ready, 1);

        // Single write.
        send(3'h4, 1'b1, 12'hDED);
        wait_idle(100);
        check_eq("write_no_rsp", rsp_valid, 0);

        // Single read with a known SSP_DO.
        fixed_do = 1;
        send(3'h2, 1'b0, 12'h7FF);
        wait_idle(100);
        check_eq("read_rsp_valid", rsp_valid, 1);
        check_eq("read_rsp_do", rsp_do, 12'h5A3);
        check_eq("read_rsp_ra", rsp_ra, 3'h2);
        fixed_do = 0;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check_eq("read_rsp_cleared", rsp_valid, 0);

        // Burst of five writes, valid held.
        for (int i = 0; i < 5; i++) send(3'(i), 1'b1, 12'($urandom));
        wait_idle(200);

        // Two reads with the consumer stalled.
        send(3'h1, 1'b0, 12'h0);
        send(3'h5, 1'b0, 12'h0);
        repeat (60) tick();
        check_eq("rd2_stalled_busy", busy, 1);
        check_eq("rd1_kept_ra", rsp_ra, 3'h1);
        rsp_ready = 1;
        wait_idle(100);
        rsp_ready = 0;

        // Read then write, consumer stalled: the write still goes out after the read.
        send(3'h3, 1'b0, 12'h0);
        send(3'h6, 1'b1, 12'hABC);
        repeat (60) tick();
        check_eq("rdwr_rsp_ra", rsp_ra, 3'h3);
        check_eq("rdwr_ssp_ra", ra, 3'h6);
        check_eq("rdwr_done", busy, 0);
        // A second read now blocks, and the write behind it waits in order.
        send(3'h0, 1'b0, 12'h0);
        send(3'h7, 1'b1, 12'h321);
        repeat (60) tick();
        check_eq("rd_blocked_busy", busy, 1);
        check_eq("rd_blocked_ra", ra, 3'h6);
        rsp_ready = 1;
        wait_idle(100);
        rsp_ready = 0;

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_ra    = 3'($urandom);
            cmd_wnr   = 1'($urandom_range(0, 1));
            cmd_di    = 12'($urandom);
            rsp_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        cmd_valid = 0;
        rsp_ready = 1;
        wait_idle(400);
        rsp_ready = 0;

        // Reset in the middle of a frame with entries queued.
        begin
            bit hit;
            hit = 0;
            send(3'h1, 1'b1, 12'h111);
            send(3'h2, 1'b1, 12'h222);
            send(3'h3, 1'b1, 12'h333);
            for (int k = 0; k < 100 && !hit; k++) begin
                if (pos == 7) hit = 1;
                else tick();
            end
            if (!hit) check_eq("midframe_reached", {31'b0, hit}, 1);
        end
        #2 rst = 1;
        #1;
        check_eq("rst_ssel", ssel, 0);
        check_eq("rst_sof", sof, 0);
        check_eq("rst_eoc", eoc, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", cmd_ready, 0);
        tick();
        tick();
        rst = 0;
        tick();
        check_eq("ready_after_midreset", cmd_ready, 1);
        check_eq("busy_after_midreset", busy, 0);
        send(3'h5, 1'b1, 12'h123);
        wait_idle(100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
